hmac_msg_feeder: RTL and testbench
==================================

Name: hmac_msg_feeder

Overview:
Upstream stage for hmac_spongent_iter. It accepts a message as a byte stream using valid/ready/last signalling. It packs the bytes into r-bit words and presents each word to the hash core on feed_data/data_ready, paced by the core's busy. It asserts stop_feed with the final word, waits for end_hmac, then pulses done and returns to idle.

Parameters:
R_WIDTH, 16, rate width r; must equal the core's r and be a multiple of 8
CNT_WIDTH, 16, width of the issued-word counter

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-low reset
start  in  1  one-cycle pulse that begins a message; ignored unless in IDLE
byte_i  in  8  message byte
byte_valid_i  in  1  byte_i is valid
byte_last_i  in  1  marks the final byte of the message; qualified by byte_valid_i
byte_ready_o  out  1  feeder accepts byte_i this cycle
feed_data  out  R_WIDTH  packed word to the core
data_ready  out  1  one-cycle strobe: feed_data is valid
stop_feed  out  1  level; the current/last word ends the message
busy  in  1  core busy absorbing/permuting
end_hmac  in  1  core finished the digest
done  out  1  one-cycle pulse after end_hmac
words_o  out  CNT_WIDTH  number of words issued for the current message

Behaviour:
- Constant K = R_WIDTH/8 bytes per word. Byte index bidx counts 0..K-1. The first byte received goes to the MSBs: byte j occupies bits [R_WIDTH-1-8j -: 8].
- Reset (rst=0 at a clk edge) has priority over everything, in any state:
  - state=IDLE.
  - feed_data=0, data_ready=0, stop_feed=0, byte_ready_o=0, done=0, words_o=0, bidx=0.
- IDLE:
  - byte_ready_o=0.
  - On start: clear the shift register, bidx and words_o; set stop_feed=0; go to COLLECT.
- COLLECT:
  - byte_ready_o=1. A byte is accepted on byte_valid_i & byte_ready_o, and is written into slot bidx.
  - If bidx==K-1 or byte_last_i: go to ISSUE on the next cycle. On byte_last_i, also set the internal last flag.
  - If byte_last_i arrives with bidx<K-1: the remaining slots are zero.
- ISSUE:
  - byte_ready_o=0.
  - While busy==1: hold.
  - When busy==0: drive data_ready=1 for exactly one cycle with feed_data stable. The same cycle sets words_o+=1, wrapping modulo 2^CNT_WIDTH. If the last flag is set, stop_feed goes high in that same cycle.
  - Go to WAIT_ACK.
- WAIT_ACK:
  - Wait for busy==1. Required timeout is 2 cycles: if busy stays 0 for 2 cycles, treat the word as accepted.
  - Then go to WAIT_FREE.
- WAIT_FREE:
  - Wait for busy==0.
  - If the last flag is set: go to WAIT_DONE.
  - Otherwise: clear the shift register and bidx, and go to COLLECT.
- WAIT_DONE:
  - stop_feed stays high.
  - On end_hmac: pulse done=1 for one cycle and go to IDLE. stop_feed is cleared in the next IDLE cycle.
  - end_hmac seen in any state other than WAIT_DONE is ignored.
- Latency:
  - Last byte accepted to data_ready: 1 cycle minimum when busy==0.
  - end_hmac to done: 1 cycle.
- feed_data holds its last value until the next ISSUE. It does not change while data_ready is low.
- Zero-length messages are not supported. The message starts at the first accepted byte.
- Simultaneous events:
  - start outside IDLE: ignored.
  - byte_valid_i outside COLLECT: not accepted, because byte_ready_o=0.
  - A start pulse is not accepted as a byte in the same cycle; COLLECT begins the cycle after start.

Decomposition:
- Package hmac_feeder_pkg holds the state enum (IDLE, COLLECT, ISSUE, WAIT_ACK, WAIT_FREE, WAIT_DONE) and the localparams ACK_TIMEOUT=2 and BYTE_W=8.
- One natural sub-module, byte_packer: the K-slot shift register, bidx counter, zero-fill and full/last detection. The FSM and core handshake stay in the top module.

Test Plan:
- Reset: rst=0 during WAIT_DONE with stop_feed=1 -> next cycle all outputs 0, state IDLE; a following start works normally.
- Two bytes 0x12, 0x34 (last on 0x34), busy tied 0, end_hmac 5 cycles later -> one data_ready with feed_data=0x1234, stop_feed=1 on that cycle, words_o=1, done pulse 1 cycle after end_hmac.
- Three bytes 0xAA, 0xBB, 0xCC (last) -> words 0xAABB with stop_feed=0, then 0xCC00 with stop_feed=1; words_o=2.
- Core busy=1 for 20 cycles when the word is ready -> data_ready held off until busy falls, then exactly one strobe; byte_ready_o=0 throughout.
- Core never raises busy after a strobe -> after the 2-cycle timeout the feeder returns to COLLECT and accepts the next byte.
- Stray start and end_hmac in COLLECT -> no effect; a byte with byte_valid_i=0 is never packed; bidx unchanged.

Source files
------------

// File: rtl/hmac_feeder_pkg.sv
// Shared types and constants for the HMAC message feeder.
// Feeder FSM states plus byte width and the busy-acknowledge timeout.
package hmac_feeder_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        COLLECT   = 3'd1,
        ISSUE     = 3'd2,
        WAIT_ACK  = 3'd3,
        WAIT_FREE = 3'd4,
        WAIT_DONE = 3'd5
    } state_e;

    localparam int ACK_TIMEOUT = 2;
    localparam int BYTE_W      = 8;

endpackage

// File: rtl/hmac_msg_feeder_byte_packer.sv
// Packs bytes MSB-first into one rate-width word; unwritten slots stay zero
// because the register is cleared before each word is collected.
module byte_packer
    import hmac_feeder_pkg::*;
#(
    parameter int  R_WIDTH = 16,
    localparam int K       = R_WIDTH / BYTE_W,
    localparam int IDX_W   = (K > 1) ? $clog2(K) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               wr_en,
    input  logic [BYTE_W-1:0]  byte_in,
    input  logic               last_in,
    output logic [R_WIDTH-1:0] word,
    output logic [IDX_W-1:0]   bidx,
    output logic               close
);

    // The word closes on the byte that fills the last slot or carries last.
    assign close = wr_en & ((bidx == IDX_W'(K - 1)) | last_in);

    always_ff @(posedge clk) begin
        if (!rst) begin
            word <= '0;
            bidx <= '0;
        end else if (clear) begin
            word <= '0;
            bidx <= '0;
        end else if (wr_en) begin
            word[R_WIDTH - 1 - BYTE_W * int'(bidx) -: BYTE_W] <= byte_in;
            if (bidx == IDX_W'(K - 1)) begin
                bidx <= '0;
            end else begin
                bidx <= bidx + IDX_W'(1);
            end
        end
    end

endmodule

// File: rtl/hmac_msg_feeder.sv
// Byte-stream to rate-word feeder in front of the sponge HMAC core.
// Handshake: a byte transfers on a clk edge where byte_valid_i & byte_ready_o are both 1.
module hmac_msg_feeder
    import hmac_feeder_pkg::*;
#(
    parameter int R_WIDTH   = 16,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [BYTE_W-1:0]    byte_i,
    input  logic                 byte_valid_i,
    input  logic                 byte_last_i,
    output logic                 byte_ready_o,
    output logic [R_WIDTH-1:0]   feed_data,
    output logic                 data_ready,
    output logic                 stop_feed,
    input  logic                 busy,
    input  logic                 end_hmac,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] words_o,
    output state_e               dbg_state
);

    localparam int K     = R_WIDTH / BYTE_W;
    localparam int IDX_W = (K > 1) ? $clog2(K) : 1;

    state_e             state;
    logic               last_flag;
    logic [1:0]         ack_cnt;
    logic               accept;
    logic               pk_clear;
    logic               pk_close;
    logic [R_WIDTH-1:0] pk_word;
    logic [IDX_W-1:0]   pk_bidx;

    assign dbg_state = state;
    assign accept    = byte_valid_i & byte_ready_o;
    // Packer restarts on a new message and after each non-final word is consumed.
    assign pk_clear  = ((state == IDLE) & start) |
                       ((state == WAIT_FREE) & ~busy & ~last_flag);

    byte_packer #(
        .R_WIDTH (R_WIDTH)
    ) u_packer (
        .clk     (clk),
        .rst     (rst),
        .clear   (pk_clear),
        .wr_en   (accept),
        .byte_in (byte_i),
        .last_in (byte_last_i),
        .word    (pk_word),
        .bidx    (pk_bidx),
        .close   (pk_close)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            feed_data    <= '0;
            data_ready   <= 1'b0;
            stop_feed    <= 1'b0;
            byte_ready_o <= 1'b0;
            done         <= 1'b0;
            words_o      <= '0;
            last_flag    <= 1'b0;
            ack_cnt      <= '0;
        end else begin
            data_ready <= 1'b0;
            done       <= 1'b0;
            case (state)
                IDLE: begin
                    byte_ready_o <= 1'b0;
                    stop_feed    <= 1'b0;
                    if (start) begin
                        words_o      <= '0;
                        last_flag    <= 1'b0;
                        byte_ready_o <= 1'b1;
                        state        <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (pk_close) begin
                        byte_ready_o <= 1'b0;
                        last_flag    <= byte_last_i;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!busy) begin
                        data_ready <= 1'b1;
                        feed_data  <= pk_word;
                        words_o    <= words_o + CNT_WIDTH'(1);
                        if (last_flag) begin
                            stop_feed <= 1'b1;
                        end
                        ack_cnt <= '0;
                        state   <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    // A core that never raises busy is assumed to have taken the word.
                    if (busy || (ack_cnt == 2'(ACK_TIMEOUT - 1))) begin
                        state <= WAIT_FREE;
                    end else begin
                        ack_cnt <= ack_cnt + 2'd1;
                    end
                end
                WAIT_FREE: begin
                    if (!busy) begin
                        if (last_flag) begin
                            state <= WAIT_DONE;
                        end else begin
                            byte_ready_o <= 1'b1;
                            state        <= COLLECT;
                        end
                    end
                end
                WAIT_DONE: begin
                    if (end_hmac) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hmac_msg_feeder.sv
// Directed bench for hmac_msg_feeder: expected words are queued by the stimulus
// and a negedge monitor pops and compares them on every data_ready strobe.
module tb_hmac_msg_feeder;
    import hmac_feeder_pkg::*;

    localparam int R  = 16;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [7:0]    byte_i = 8'h00;
    logic          byte_valid_i = 1'b0;
    logic          byte_last_i = 1'b0;
    logic          busy = 1'b0;
    logic          end_hmac = 1'b0;
    logic          byte_ready_o;
    logic [R-1:0]  feed_data;
    logic          data_ready;
    logic          stop_feed;
    logic          done;
    logic [CW-1:0] words_o;
    state_e        dbg_state;

    int checks = 0;
    int failures = 0;
    int strobes = 0;
    logic [CW+R:0] exp_q[$];
    logic [CW+R:0] mon_exp;

    hmac_msg_feeder #(.R_WIDTH(R), .CNT_WIDTH(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .byte_i       (byte_i),
        .byte_valid_i (byte_valid_i),
        .byte_last_i  (byte_last_i),
        .byte_ready_o (byte_ready_o),
        .feed_data    (feed_data),
        .data_ready   (data_ready),
        .stop_feed    (stop_feed),
        .busy         (busy),
        .end_hmac     (end_hmac),
        .done         (done),
        .words_o      (words_o),
        .dbg_state    (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [CW-1:0] w, input logic stop, input logic [R-1:0] d);
        exp_q.push_back({w, stop, d});
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        int n = 0;
        while (!byte_ready_o && n < 50) begin
            tick();
            n++;
        end
        check("byte_ready wait", 64'(n < 50), 64'd1);
        byte_valid_i = 1'b1;
        byte_i       = b;
        byte_last_i  = last;
        tick();
        byte_valid_i = 1'b0;
        byte_last_i  = 1'b0;
        byte_i       = 8'($urandom_range(0, 255));
    endtask

    task automatic wait_state(input state_e s, input string name);
        int n = 0;
        while (dbg_state != s && n < 50) begin
            tick();
            n++;
        end
        check(name, 64'(dbg_state), 64'(s));
    endtask

    task automatic wait_strobe(input string name);
        int n = 0;
        while (!data_ready && n < 50) begin
            tick();
            n++;
        end
        check(name, 64'(data_ready), 64'd1);
    endtask

    task automatic finish_msg(input string name);
        wait_state(WAIT_DONE, {name, " reach WAIT_DONE"});
        end_hmac = 1'b1;
        tick();
        end_hmac = 1'b0;
        check({name, " done pulse"}, 64'(done), 64'd1);
        tick();
        check({name, " done cleared"}, 64'(done), 64'd0);
        check({name, " idle"}, 64'(dbg_state), 64'(IDLE));
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (rst && data_ready) begin
            strobes++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected strobe: got data 0x%0h stop %0b words %0d, expected none",
                         feed_data, stop_feed, words_o);
            end else begin
                mon_exp = exp_q.pop_front();
                check("strobe {words,stop,data}", 64'({words_o, stop_feed, feed_data}), 64'(mon_exp));
            end
        end
    end

    initial begin
        int s0;
        logic bad;

        // power-on reset
        rst = 1'b0;
        repeat (2) tick();
        check("por state", 64'(dbg_state), 64'(IDLE));
        check("por byte_ready", 64'(byte_ready_o), 64'd0);
        check("por words", 64'(words_o), 64'd0);
        rst = 1'b1;
        tick();

        // A: two bytes 12 34, busy tied low
        do_start();
        check("A collect", 64'(dbg_state), 64'(COLLECT));
        check("A byte_ready", 64'(byte_ready_o), 64'd1);
        push_exp(16'd1, 1'b1, 16'h1234);
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b1);
        check("A no strobe yet", 64'(data_ready), 64'd0);
        tick();
        check("A data_ready latency", 64'(data_ready), 64'd1);
        check("A stop_feed with strobe", 64'(stop_feed), 64'd1);
        repeat (4) tick();
        check("A wait_done", 64'(dbg_state), 64'(WAIT_DONE));
        check("A stop_feed held", 64'(stop_feed), 64'd1);
        check("A no early done", 64'(done), 64'd0);
        end_hmac = 1'b1;
        tick();
        end_hmac = 1'b0;
        check("A done pulse", 64'(done), 64'd1);
        check("A stop_feed in done cycle", 64'(stop_feed), 64'd1);
        tick();
        check("A done cleared", 64'(done), 64'd0);
        check("A stop_feed cleared", 64'(stop_feed), 64'd0);
        check("A idle", 64'(dbg_state), 64'(IDLE));
        check("A words", 64'(words_o), 64'd1);

        // B: three bytes AA BB CC, then reset in WAIT_DONE
        do_start();
        push_exp(16'd1, 1'b0, 16'hAABB);
        push_exp(16'd2, 1'b1, 16'hCC00);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        send_byte(8'hCC, 1'b1);
        wait_state(WAIT_DONE, "B reach WAIT_DONE");
        check("B words", 64'(words_o), 64'd2);
        check("B stop_feed", 64'(stop_feed), 64'd1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("B rst state", 64'(dbg_state), 64'(IDLE));
        check("B rst outputs", 64'({feed_data, data_ready, stop_feed, byte_ready_o, done, words_o}), 64'd0);

        // C: core busy for 20 cycles when the word is ready
        busy = 1'b1;
        do_start();
        push_exp(16'd1, 1'b1, 16'h5566);
        s0 = strobes;
        send_byte(8'h55, 1'b0);
        send_byte(8'h66, 1'b1);
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (data_ready || byte_ready_o) bad = 1'b1;
        end
        check("C held off while busy", 64'(bad), 64'd0);
        busy = 1'b0;
        wait_strobe("C strobe after busy falls");
        busy = 1'b1;
        repeat (4) tick();
        busy = 1'b0;
        finish_msg("C");
        check("C single strobe", 64'(strobes - s0), 64'd1);

        // D: stray start/end_hmac in COLLECT, then core never raises busy
        do_start();
        push_exp(16'd1, 1'b0, 16'h0102);
        push_exp(16'd2, 1'b1, 16'h0300);
        send_byte(8'h01, 1'b0);
        start    = 1'b1;
        end_hmac = 1'b1;
        byte_i   = 8'hFF;
        tick();
        start    = 1'b0;
        end_hmac = 1'b0;
        tick();
        check("D stray ignored state", 64'(dbg_state), 64'(COLLECT));
        check("D stray byte_ready", 64'(byte_ready_o), 64'd1);
        check("D stray words", 64'(words_o), 64'd0);
        send_byte(8'h02, 1'b0);
        wait_strobe("D first strobe");
        wait_state(COLLECT, "D timeout back to COLLECT");
        send_byte(8'h03, 1'b1);
        finish_msg("D");
        check("D words", 64'(words_o), 64'd2);

        repeat (3) tick();
        check("scoreboard drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
